pipe_memory_writeback: RTL
==========================

Name: pipe_memory_writeback

Overview:
Pipeline stage directly downstream of the operation stage. It consumes the operation stage's load/store control and result outputs. It runs the data-bus transaction for loads and stores, and aligns and sign- or zero-extends load data. It then produces the single register-file write for the retiring instruction, and stalls the pipe while a bus access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles in REQUEST before the access is abandoned; legal range 1..255.
TIMEOUT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  core clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
stepPipe  input  1  pipe advance strobe; captures the stage inputs
currentInstruction  input  32  instruction from the operation stage; rd = [11:7], funct3 = [14:12]
operationResultStoreEnable  input  1  instruction writes rd
operationResult  input  32  rd value for non-load instructions
memoryEnable  input  1  load or store request
memoryWriteEnable  input  1  request is a store
memoryByteSelect  input  4  byte lanes
memoryAddress  input  32  word-aligned address
fullMemoryAddress  input  32  byte address; bits [1:0] used for load alignment
memoryWriteData  input  32  lane-aligned store data
busAddress  output  32  data bus address
busEnable  output  1  bus request
busWriteEnable  output  1  bus write
busByteSelect  output  4  bus lanes
busDataWrite  output  32  bus write data
busDataRead  input  32  bus read data; valid when busEnable=1 and busBusy=0
busBusy  input  1  target not yet complete
currentPipeStall  output  1  stage busy; upstream must hold
active  output  1  stage holds a valid instruction
registerWriteEnable  output  1  rd write strobe
registerWriteAddress  output  5  rd index
registerWriteData  output  32  rd value
loadStoreTimeout  output  1  one-cycle pulse when an access is abandoned

Behaviour:
- Reset (rst=0), asynchronous: state=IDLE. active, currentPipeStall, busEnable, busWriteEnable, registerWriteEnable and loadStoreTimeout = 0. Address, data and lane outputs = 0. Timeout counter = 0.
- Reset mid-transaction: busEnable drops immediately and no writeback occurs.
- States: IDLE, REQUEST, WRITEBACK.
- IDLE + stepPipe:
  - Latch all inputs, rd and funct3; active=1.
  - If memoryEnable=1: go to REQUEST.
  - Else if operationResultStoreEnable=1: go to WRITEBACK.
  - Else: stay in IDLE; active=1 for one cycle.
- IDLE without stepPipe: active=0.
- REQUEST:
  - busEnable=1, busWriteEnable=latched write enable; bus address, lanes and data driven from latches, stable until completion.
  - currentPipeStall=1; counter increments each cycle that busBusy=1.
  - busBusy=0: access completes in that cycle; for loads, capture busDataRead.
    - Load: go to WRITEBACK. Store: go to IDLE with no register write.
  - Counter reaches TIMEOUT_CYCLES with busBusy still 1: pulse loadStoreTimeout, drop busEnable, go to IDLE, no register write.
  - Earliest completion: the first REQUEST cycle (one cycle after the stepPipe capture).
- WRITEBACK (one cycle):
  - registerWriteEnable=1 unless rd=0; never write x0.
  - Then go to IDLE. currentPipeStall=0 in this cycle, so a new stepPipe is accepted in the same cycle.
- Load data: shift captured read data right by 8*fullMemoryAddress[1:0]. Then by funct3:
  - 000 LB: sign-extend [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: no extension.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - Other values: write 0.
- Non-load writeback data = latched operationResult.
- stepPipe while currentPipeStall=1: ignored; latches do not change.
- Timeout counter clears on every entry to REQUEST.
- A simultaneous busBusy=0 and timeout expiry counts as completion; no timeout pulse.

Test Plan:
- Non-memory op: ADDI x5, stepPipe, operationResult=0x1234 -> next cycle registerWriteEnable=1, address 5, data 0x00001234; stall never asserted.
- LB sign: fullMemoryAddress=0x1003, busDataRead=0x80000000, busBusy=0 on the first REQUEST cycle -> busEnable for one cycle, then writeback data 0xFFFFFF80.
- LHU with wait states: address 0x2002, busBusy high for 3 cycles, read data 0xBEEF0000 -> currentPipeStall held for 4 cycles; writeback 0x0000BEEF.
- Store SW: address 0x3000, data 0xCAFEF00D, lanes 1111 -> bus outputs match the latched values while busy; no register write after completion.
- Timeout: TIMEOUT_CYCLES=4, busBusy held at 1 -> loadStoreTimeout pulses once after 4 busy cycles; busEnable=0 and no register write.
- rd=x0 load, and async reset asserted during REQUEST -> no write to x0; busEnable=0 immediately on reset; state IDLE after reset release.

Source files
------------

// File: rtl/pipe_memory_writeback.sv
// Memory/writeback stage: runs the data-bus access for loads and stores,
// aligns and extends load data, and issues the single register-file write
// for the retiring instruction. Holds the pipe while a bus access is open.
module pipe_memory_writeback #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stepPipe,
    input  logic [31:0] currentInstruction,
    input  logic        operationResultStoreEnable,
    input  logic [31:0] operationResult,
    input  logic        memoryEnable,
    input  logic        memoryWriteEnable,
    input  logic [3:0]  memoryByteSelect,
    input  logic [31:0] memoryAddress,
    input  logic [31:0] fullMemoryAddress,
    input  logic [31:0] memoryWriteData,
    output logic [31:0] busAddress,
    output logic        busEnable,
    output logic        busWriteEnable,
    output logic [3:0]  busByteSelect,
    output logic [31:0] busDataWrite,
    input  logic [31:0] busDataRead,
    input  logic        busBusy,
    output logic        currentPipeStall,
    output logic        active,
    output logic        registerWriteEnable,
    output logic [4:0]  registerWriteAddress,
    output logic [31:0] registerWriteData,
    output logic        loadStoreTimeout
);

    typedef enum logic [1:0] {IDLE, REQUEST, WRITEBACK} stateT;

    stateT state;
    stateT nextState;

    // Instruction fields captured on acceptance (stage p0) and load data (p1)
    logic [4:0]  rdP0;
    logic [2:0]  funct3P0;
    logic [31:0] resultP0;
    logic        writeP0;
    logic        isLoadP0;
    logic [3:0]  byteSelP0;
    logic [31:0] addrP0;
    logic [1:0]  offsetP0;
    logic [31:0] writeDataP0;
    logic [31:0] readDataP1;

    logic [TIMEOUT_WIDTH-1:0] timeoutCount;
    logic [TIMEOUT_WIDTH-1:0] countNext;
    logic                     accept;
    logic                     expire;

    // Instruction bits and address bits this stage never looks at
    logic unusedInputs;
    assign unusedInputs = ^{currentInstruction[31:15], currentInstruction[6:0],
                            fullMemoryAddress[31:2]};

    // A new instruction is taken whenever the stage is not stalled
    assign accept    = stepPipe && (state != REQUEST);
    assign countNext = timeoutCount + TIMEOUT_WIDTH'(1);
    assign expire    = busBusy && (countNext == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));

    // Shift the read word down to the addressed byte, then extend per funct3
    function automatic logic [31:0] loadAlign(input logic [31:0] raw,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
        logic        [31:0] shifted;
        logic signed [7:0]  sByte;
        logic signed [15:0] sHalf;
        shifted = raw >> {offset, 3'b000};
        sByte   = shifted[7:0];
        sHalf   = shifted[15:0];
        case (funct3)
            3'b000:  loadAlign = 32'(sByte);
            3'b001:  loadAlign = 32'(sHalf);
            3'b010:  loadAlign = shifted;
            3'b100:  loadAlign = {24'd0, shifted[7:0]};
            3'b101:  loadAlign = {16'd0, shifted[15:0]};
            default: loadAlign = 32'd0;
        endcase
    endfunction

    // Control state: FSM, active flag, timeout counter and timeout pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            active           <= 1'b0;
            loadStoreTimeout <= 1'b0;
            timeoutCount     <= '0;
        end else begin
            state            <= nextState;
            active           <= accept || (nextState != IDLE);
            loadStoreTimeout <= (state == REQUEST) && expire;
            if (accept && memoryEnable) begin
                timeoutCount <= '0;
            end else if ((state == REQUEST) && busBusy) begin
                timeoutCount <= countNext;
            end
        end
    end

    // Datapath capture: instruction latches on accept, read data on completion
    always_ff @(posedge clk) begin
        if (accept) begin
            rdP0        <= currentInstruction[11:7];
            funct3P0    <= currentInstruction[14:12];
            resultP0    <= operationResult;
            writeP0     <= memoryWriteEnable;
            isLoadP0    <= memoryEnable && !memoryWriteEnable;
            byteSelP0   <= memoryByteSelect;
            addrP0      <= memoryAddress;
            offsetP0    <= fullMemoryAddress[1:0];
            writeDataP0 <= memoryWriteData;
        end
        if ((state == REQUEST) && !busBusy) begin
            readDataP1 <= busDataRead;
        end
    end

    // Next-state decode and state-derived bus / register-file outputs
    always_comb begin
        nextState            = state;
        busEnable            = 1'b0;
        busWriteEnable       = 1'b0;
        busAddress           = '0;
        busByteSelect        = '0;
        busDataWrite         = '0;
        currentPipeStall     = 1'b0;
        registerWriteEnable  = 1'b0;
        registerWriteAddress = '0;
        registerWriteData    = '0;
        case (state)
            IDLE, WRITEBACK: begin
                if (state == WRITEBACK) begin
                    registerWriteEnable  = (rdP0 != 5'd0);
                    registerWriteAddress = rdP0;
                    registerWriteData    = isLoadP0 ? loadAlign(readDataP1, offsetP0, funct3P0)
                                                    : resultP0;
                end
                nextState = IDLE;
                if (accept) begin
                    if (memoryEnable) begin
                        nextState = REQUEST;
                    end else if (operationResultStoreEnable) begin
                        nextState = WRITEBACK;
                    end
                end
            end
            REQUEST: begin
                busEnable        = 1'b1;
                busWriteEnable   = writeP0;
                busAddress       = addrP0;
                busByteSelect    = byteSelP0;
                busDataWrite     = writeDataP0;
                currentPipeStall = 1'b1;
                if (!busBusy) begin
                    nextState = writeP0 ? IDLE : WRITEBACK;
                end else if (expire) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule
